// File: rtl/fetch_buffer.sv
// Instruction queue between I-cache and decode: splits 64-bit fetch packets into per-instruction entries.
// Latency: an accepted packet is visible at the outputs one cycle later (no bypass); outputs read head/head+1 combinationally.
// Backpressure: in_ready depends only on the registered count (room for two entries); flush empties next cycle.
// Optional: define FETCH_BUFFER_STAT_EN to add stat_full_cycles / stat_empty_cycles counters.
module fetch_buffer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [63:0] in_data,
    input  logic [6:0]  in_exception,
    output logic        out_valid0,
    output logic        out_valid1,
    output logic [31:0] out_inst0,
    output logic [31:0] out_inst1,
    output logic [31:0] out_pc0,
    output logic [31:0] out_pc1,
    output logic [6:0]  out_exc0,
    output logic [6:0]  out_exc1,
    input  logic [1:0]  out_pop
`ifdef FETCH_BUFFER_STAT_EN
    ,
    output logic [31:0] stat_full_cycles,
    output logic [31:0] stat_empty_cycles
`endif
);

    localparam int CW = PTR_W + 1;
    localparam logic [31:0] NOP_INST = 32'h0340_0000;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [6:0]  exc;
    } entry_t;

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CW-1:0]    count;

    logic [PTR_W-1:0] head1;
    logic [PTR_W-1:0] tail1;
    logic             push_en;
    logic [CW-1:0]    push_n;
    logic [CW-1:0]    pop_req;
    logic [CW-1:0]    pop_n;
    entry_t           ent0;
    entry_t           ent1;

    assign head1    = head + PTR_W'(1);
    assign tail1    = tail + PTR_W'(1);
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign push_en  = in_valid & in_ready & ~flush;

    // Decode never pops more than it sees valid, but clamp so a bad pop cannot underflow the count.
    assign pop_req = CW'(out_pop);
    assign pop_n   = (pop_req > count) ? count : pop_req;

    always_comb begin
        push_n = '0;
        ent0   = '0;
        ent1   = '0;
        if (push_en) begin
            if (in_exception != 7'd0) begin
                push_n    = CW'(1);
                ent0.inst = NOP_INST;
                ent0.pc   = in_pc;
                ent0.exc  = in_exception;
            end else if (!in_pc[2]) begin
                push_n    = CW'(2);
                ent0.inst = in_data[31:0];
                ent0.pc   = in_pc;
                ent1.inst = in_data[63:32];
                ent1.pc   = in_pc + 32'd4;
            end else begin
                // Packet fetched from the upper word: only the second slot is on the path.
                push_n    = CW'(1);
                ent0.inst = in_data[63:32];
                ent0.pc   = in_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push_n != '0) begin
                mem[tail] <= ent0;
            end
            if (push_n == CW'(2)) begin
                mem[tail1] <= ent1;
            end
            head  <= head + PTR_W'(pop_n);
            tail  <= tail + PTR_W'(push_n);
            count <= count + push_n - pop_n;
        end
    end

    assign out_valid0 = (count >= CW'(1));
    assign out_valid1 = (count >= CW'(2));
    assign out_inst0  = mem[head].inst;
    assign out_pc0    = mem[head].pc;
    assign out_exc0   = mem[head].exc;
    assign out_inst1  = mem[head1].inst;
    assign out_pc1    = mem[head1].pc;
    assign out_exc1   = mem[head1].exc;

`ifdef FETCH_BUFFER_STAT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_full_cycles  <= '0;
            stat_empty_cycles <= '0;
        end else begin
            if (!in_ready && in_valid) begin
                stat_full_cycles <= stat_full_cycles + 32'd1;
            end
            if (count == '0 && !flush) begin
                stat_empty_cycles <= stat_empty_cycles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_buffer.sv
// Directed bench for fetch_buffer (DEPTH=8): split/alignment/exception pushes, fill and wrap, push+pop, flush.
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [63:0] in_data;
    logic [6:0]  in_exception;
    logic        out_valid0;
    logic        out_valid1;
    logic [31:0] out_inst0;
    logic [31:0] out_inst1;
    logic [31:0] out_pc0;
    logic [31:0] out_pc1;
    logic [6:0]  out_exc0;
    logic [6:0]  out_exc1;
    logic [1:0]  out_pop;
`ifdef FETCH_BUFFER_STAT_EN
    logic [31:0] stat_full_cycles;
    logic [31:0] stat_empty_cycles;
`endif

    int passed = 0;
    int total  = 0;

    fetch_buffer #(.DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_pc        (in_pc),
        .in_data      (in_data),
        .in_exception (in_exception),
        .out_valid0   (out_valid0),
        .out_valid1   (out_valid1),
        .out_inst0    (out_inst0),
        .out_inst1    (out_inst1),
        .out_pc0      (out_pc0),
        .out_pc1      (out_pc1),
        .out_exc0     (out_exc0),
        .out_exc1     (out_exc1),
        .out_pop      (out_pop)
`ifdef FETCH_BUFFER_STAT_EN
        ,
        .stat_full_cycles  (stat_full_cycles),
        .stat_empty_cycles (stat_empty_cycles)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic push(input logic [31:0] pc, input logic [63:0] data, input logic [6:0] exc);
        in_valid     = 1'b1;
        in_pc        = pc;
        in_data      = data;
        in_exception = exc;
        step();
        in_valid     = 1'b0;
        in_exception = 7'd0;
    endtask

    task automatic pop(input logic [1:0] n);
        out_pop = n;
        step();
        out_pop = 2'd0;
    endtask

    logic [31:0] pc_w;
    logic [31:0] pc_r;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_pc = '0; in_data = '0;
        in_exception = '0; out_pop = 2'd0;
        step();
        step();
        rst = 1'b0;

        check("rst_valid0", 32'(out_valid0), 32'd0);
        check("rst_valid1", 32'(out_valid1), 32'd0);
        check("rst_ready",  32'(in_ready),   32'd1);
        check("rst_inst0",  out_inst0,       32'd0);
        check("rst_pc0",    out_pc0,         32'd0);
        check("rst_exc0",   32'(out_exc0),   32'd0);
        check("rst_inst1",  out_inst1,       32'd0);

        // Aligned packet splits into two entries.
        push(32'h1C00_0000, 64'h0000_0002_0000_0001, 7'd0);
        check("al_valid0", 32'(out_valid0), 32'd1);
        check("al_inst0",  out_inst0,       32'h1);
        check("al_pc0",    out_pc0,         32'h1C00_0000);
        check("al_exc0",   32'(out_exc0),   32'd0);
        check("al_valid1", 32'(out_valid1), 32'd1);
        check("al_inst1",  out_inst1,       32'h2);
        check("al_pc1",    out_pc1,         32'h1C00_0004);
        pop(2'd2);
        check("al_drained", 32'(out_valid0), 32'd0);

        // Upper-word packet gives one entry from data[63:32].
        push(32'h1C00_0004, 64'hAAAA_BBBB_CCCC_DDDD, 7'd0);
        check("hi_inst0",  out_inst0,       32'hAAAA_BBBB);
        check("hi_pc0",    out_pc0,         32'h1C00_0004);
        check("hi_valid1", 32'(out_valid1), 32'd0);
        pop(2'd1);

        // Exception packet: single nop entry carrying the code.
        push(32'h1C00_0010, 64'hFFFF_FFFF_FFFF_FFFF, 7'h08);
        check("ex_valid0", 32'(out_valid0), 32'd1);
        check("ex_inst0",  out_inst0,       32'h0340_0000);
        check("ex_pc0",    out_pc0,         32'h1C00_0010);
        check("ex_exc0",   32'(out_exc0),   32'h08);
        check("ex_valid1", 32'(out_valid1), 32'd0);
        pop(2'd1);

        // Three fill/drain rounds; each entry's inst equals its pc so order is checked by value.
        pc_w = 32'h100;
        pc_r = 32'h100;
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < 4; p++) begin
                check("fill_ready", 32'(in_ready), 32'd1);
                push(pc_w, {pc_w + 32'd4, pc_w}, 7'd0);
                pc_w = pc_w + 32'd8;
            end
            check("full_ready", 32'(in_ready), 32'd0);
            push(32'hDEAD_0000, 64'h1111_2222_3333_4444, 7'd0);
            check("full_reject_pc0", out_pc0, pc_r);
            pop(2'd1);
            pc_r = pc_r + 32'd4;
            check("cnt7_ready", 32'(in_ready), 32'd0);
            for (int k = 0; k < 4; k++) begin
                check("wrap_pc0",   out_pc0,   pc_r);
                check("wrap_inst0", out_inst0, pc_r);
                if (k < 3) begin
                    check("wrap_pc1", out_pc1, pc_r + 32'd4);
                end
                pop(2'd2);
                pc_r = pc_r + 32'd8;
                if (k == 0) begin
                    check("cnt5_ready", 32'(in_ready), 32'd1);
                end
            end
            check("drain_valid0", 32'(out_valid0), 32'd0);
            pc_r = pc_w;
        end

        // count=3, then push two while popping two.
        push(32'h200, {32'h204, 32'h200}, 7'd0);
        push(32'h20C, {32'h20C, 32'hDEAD_BEEF}, 7'd0);
        check("c3_pc0", out_pc0, 32'h200);
        in_valid = 1'b1; in_pc = 32'h210; in_data = {32'h214, 32'h210}; out_pop = 2'd2;
        step();
        in_valid = 1'b0; out_pop = 2'd0;
        check("pp_pc0",    out_pc0,         32'h20C);
        check("pp_inst0",  out_inst0,       32'h20C);
        check("pp_pc1",    out_pc1,         32'h210);
        pop(2'd2);
        check("pp_last_pc0",  out_pc0,         32'h214);
        check("pp_last_v1",   32'(out_valid1), 32'd0);
        pop(2'd1);

        // count=5, then flush against a concurrent push and pop.
        push(32'h300, {32'h304, 32'h300}, 7'd0);
        push(32'h308, {32'h30C, 32'h308}, 7'd0);
        push(32'h314, {32'h314, 32'h0}, 7'd0);
        check("f5_pc0", out_pc0, 32'h300);
        in_valid = 1'b1; in_pc = 32'h400; in_data = {32'h404, 32'h400};
        out_pop = 2'd1; flush = 1'b1;
        step();
        in_valid = 1'b0; out_pop = 2'd0; flush = 1'b0;
        check("fl_valid0", 32'(out_valid0), 32'd0);
        check("fl_valid1", 32'(out_valid1), 32'd0);
        check("fl_ready",  32'(in_ready),   32'd1);
        push(32'h500, {32'h504, 32'h500}, 7'd0);
        check("fl_after_pc0", out_pc0, 32'h500);
        check("fl_after_pc1", out_pc1, 32'h504);
        pop(2'd2);
        check("fl_after_empty", 32'(out_valid0), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
